// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the boot-time program loader.
//   state_t   - loader FSM state encoding (CHECK exists only when the
//               PROGRAM_LOADER_CHECKSUM_EN build option is used)
//   MAX_DEPTH - largest instruction memory a length byte can describe
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    RUN   = 3'd4,
    ERROR = 3'd5,
    CHECK = 3'd6
  } state_t;

  localparam int MAX_DEPTH = 255;

endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: byte stream valid/ready channel feeding the loader.
//   in_valid - source has a byte on in_data
//   in_data  - stream byte
//   in_ready - loader consumes the byte this cycle
// master modport: the byte source; slave modport: the loader.
interface program_loader_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/byte_packer.sv
// byte_packer: collects four bytes little-endian into a 32-bit word.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   clear      - restart at byte lane 0 (buffer contents are kept)
//   strobe     - data is a new byte for the current lane
//   data       - byte in
//   word       - packed word (lane k holds bits [8k+7:8k])
//   word_full  - this strobe supplies the 4th byte of the word
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        strobe,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] idx_reg;

  // The index wraps 3 -> 0 on the 4th byte, so the next word starts at lane 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_reg <= 2'd0;
    end else if (clear) begin
      idx_reg <= 2'd0;
    end else if (strobe) begin
      idx_reg <= idx_reg + 2'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          lane_reg <= 8'd0;
        end else if (strobe && !clear && idx_reg == 2'(gi)) begin
          lane_reg <= data;
        end
      end

      assign word[8*gi +: 8] = lane_reg;
    end
  endgenerate

  assign word_full = strobe && !clear && (idx_reg == 2'd3);

endmodule

// File: rtl/program_loader.sv
// program_loader: boot-time loader that packs a byte stream into 32-bit
// instructions, writes them to instruction memory from address 0, then
// releases the datapath with core_run.
// Stream format: length byte N (1..DEPTH), then 4*N bytes little-endian.
// Build option: PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// that must match the XOR of all data bytes before core_run is raised.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   load_start  - pulse that begins a (re)load from IDLE, RUN or ERROR
//   in_bus      - byte stream (slave side)
//   imem_we/imem_addr/imem_wdata - one-cycle instruction memory write
//   core_run    - datapath released
//   word_count  - words written in the current or last load
//   busy        - load in progress (LEN, DATA, WRITE)
//   err         - sticky load error, cleared by load_start
module program_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  program_loader_if.slave   in_bus,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_run,
  output logic [7:0]        word_count,
  output logic              busy,
  output logic              err
);

  localparam logic [7:0] DEPTH_B = 8'((DEPTH > MAX_DEPTH) ? MAX_DEPTH : DEPTH);

  state_t      state_reg, state_next;
  logic [7:0]  n_reg;
  logic [7:0]  count_reg;
  logic        err_reg;
  logic        ready;
  logic        accept;
  logic        len_take;
  logic        set_err;
  logic        clr_err;
  logic        word_full;
  logic [31:0] word;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] xor_reg;
`endif

  assign accept   = in_bus.in_valid && ready;
  assign len_take = accept && (state_reg == LEN);

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (len_take),
    .strobe    (accept && (state_reg == DATA)),
    .data      (in_bus.in_data),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    imem_we    = 1'b0;
    set_err    = 1'b0;
    clr_err    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load_start) begin
          state_next = LEN;
          clr_err    = 1'b1;
        end
      end
      LEN: begin
        ready = 1'b1;
        if (accept) begin
          if (in_bus.in_data == 8'd0 || in_bus.in_data > DEPTH_B) begin
            state_next = ERROR;
            set_err    = 1'b1;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        ready = 1'b1;
        if (word_full) state_next = WRITE;
      end
      WRITE: begin
        imem_we = 1'b1;
        if (count_reg + 8'd1 == n_reg) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = RUN;
`endif
        end else begin
          state_next = DATA;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK: begin
        ready = 1'b1;
        if (accept) begin
          if (in_bus.in_data == xor_reg) begin
            state_next = RUN;
          end else begin
            state_next = ERROR;
            set_err    = 1'b1;
          end
        end
      end
`endif
      RUN, ERROR: begin
        if (load_start) begin
          state_next = LEN;
          clr_err    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_reg     <= 8'd0;
      count_reg <= 8'd0;
      err_reg   <= 1'b0;
    end else begin
      if (len_take) begin
        n_reg     <= in_bus.in_data;
        count_reg <= 8'd0;
      end else if (imem_we) begin
        count_reg <= count_reg + 8'd1;
      end
      if (set_err) begin
        err_reg <= 1'b1;
      end else if (clr_err) begin
        err_reg <= 1'b0;
      end
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xor_reg <= 8'd0;
    end else if (len_take) begin
      xor_reg <= 8'd0;
    end else if (accept && state_reg == DATA) begin
      xor_reg <= xor_reg ^ in_bus.in_data;
    end
  end
`endif

  assign in_bus.in_ready = ready;
  // Address and data are forced to zero outside WRITE so the bus is quiet.
  assign imem_addr  = imem_we ? count_reg[ADDR_W-1:0] : '0;
  assign imem_wdata = imem_we ? word : 32'd0;
  assign core_run   = (state_reg == RUN);
  assign word_count = count_reg;
  assign busy       = (state_reg == LEN) || (state_reg == DATA) || (state_reg == WRITE);
  assign err        = err_reg;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: self-checking bench for program_loader.
// Table of load images (length + expected words / expected error) applied in a
// loop, plus hand-written sequences: gapped stream, full-depth load, checksum
// (PROGRAM_LOADER_CHECKSUM_EN builds) and reset in the middle of a load.
// Expected memory writes go to a scoreboard queue when the bytes are driven
// and are popped by a monitor whenever imem_we is seen.
module tb_program_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_start = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_run;
  logic [7:0]        word_count;
  logic              busy;
  logic              err;

  program_loader_if bus ();

  always #5 clk = ~clk;

  program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .in_bus     (bus),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_run   (core_run),
    .word_count (word_count),
    .busy       (busy),
    .err        (err)
  );

  typedef struct {
    logic [7:0]  len;
    logic        exp_err;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  vec_t vecs [6];
  wr_t  sb [$];
  int   checks = 0;
  int   errors = 0;
  logic prev_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Write monitor / scoreboard consumer.
  always @(negedge clk) begin
    wr_t e;
    if (imem_we) begin
      chk("we_back_to_back", 32'(prev_we), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h required=no_write", imem_addr, imem_wdata);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(e.addr));
        chk("wr_data", imem_wdata, e.data);
        $display("write addr=%0d data=%h", imem_addr, imem_wdata);
      end
    end
    prev_we = imem_we;
  end

  task automatic start_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_err_clear", 32'(err), 32'd0);
    chk("start_core_run", 32'(core_run), 32'd0);
  endtask

  // Present one byte and hold it until it is accepted (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=in_ready_low required=in_ready_high byte=%h", b);
    end else begin
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] len, input logic [31:0] words[$],
                         input logic exp_err, input bit gaps);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'd0;
    start_load();
    send_byte(len);
    if (exp_err) begin
      chk("len_err", 32'(err), 32'd1);
      chk("len_err_core_run", 32'(core_run), 32'd0);
      chk("len_err_busy", 32'(busy), 32'd0);
      chk("len_err_ready", 32'(bus.in_ready), 32'd0);
      $display("load len=%0d rejected err=%0d", len, err);
      return;
    end
    for (int w = 0; w < int'(len); w++) begin
      sb.push_back('{addr: ADDR_W'(w), data: words[w]});
      for (int k = 0; k < 4; k++) begin
        if (gaps) begin
          chk("gap_ready", 32'(bus.in_ready), (k == 0 && w > 0) ? 32'd0 : 32'd1);
          @(negedge clk);
        end
        b = words[w][8*k +: 8];
        x = x ^ b;
        send_byte(b);
      end
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(x);
`else
    @(negedge clk);
`endif
    chk("run_core_run", 32'(core_run), 32'd1);
    chk("run_word_count", 32'(word_count), 32'(len));
    chk("run_busy", 32'(busy), 32'd0);
    chk("run_ready", 32'(bus.in_ready), 32'd0);
    chk("run_sb_empty", 32'(sb.size()), 32'd0);
    $display("load len=%0d done core_run=%0d word_count=%0d", len, core_run, word_count);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_core_run", 32'(core_run), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q[$];

    vecs[0] = '{len: 8'd2,   exp_err: 1'b0, w0: 32'h00000513, w1: 32'h00150593};
    vecs[1] = '{len: 8'd0,   exp_err: 1'b1, w0: 32'h0,        w1: 32'h0};
    vecs[2] = '{len: 8'd65,  exp_err: 1'b1, w0: 32'h0,        w1: 32'h0};
    vecs[3] = '{len: 8'd1,   exp_err: 1'b0, w0: 32'h12345678, w1: 32'h0};
    vecs[4] = '{len: 8'd255, exp_err: 1'b1, w0: 32'h0,        w1: 32'h0};
    vecs[5] = '{len: 8'd2,   exp_err: 1'b0, w0: 32'hDDCCBBAA, w1: 32'h44332211};

    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(bus.in_ready), 32'd0);

    // Table-driven images (RUN->reload and ERROR->reload transitions included).
    for (int i = 0; i < 6; i++) begin
      q = {};
      if (!vecs[i].exp_err) begin
        q.push_back(vecs[i].w0);
        if (vecs[i].len > 8'd1) q.push_back(vecs[i].w1);
      end
      do_load(vecs[i].len, q, vecs[i].exp_err, 1'b0);
    end

    // Stream with in_valid low every other cycle.
    q = {};
    q.push_back(32'hCAFEF00D);
    do_load(8'd1, q, 1'b0, 1'b1);

    // Full-depth image.
    q = {};
    for (int i = 0; i < DEPTH; i++) q.push_back($urandom);
    do_load(8'(DEPTH), q, 1'b0, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Bad checksum: the word is still written, then ERROR.
    start_load();
    send_byte(8'd1);
    sb.push_back('{addr: '0, data: 32'h04030201});
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05);
    chk("cks_bad_err", 32'(err), 32'd1);
    chk("cks_bad_core_run", 32'(core_run), 32'd0);
    $display("checksum 05 err=%0d core_run=%0d", err, core_run);
    // Good checksum.
    start_load();
    send_byte(8'd1);
    sb.push_back('{addr: '0, data: 32'h04030201});
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h04);
    chk("cks_good_core_run", 32'(core_run), 32'd1);
    chk("cks_good_err", 32'(err), 32'd0);
    $display("checksum 04 err=%0d core_run=%0d", err, core_run);
`endif

    // Reset after 6 data bytes of a 2-word load: only address 0 is written.
    start_load();
    send_byte(8'd2);
    sb.push_back('{addr: '0, data: 32'h00000513});
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h05);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    chk("midrst_sb_empty", 32'(sb.size()), 32'd0);
    $display("mid-load reset core_run=%0d busy=%0d", core_run, busy);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_idle_core_run", 32'(core_run), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time instruction loader sitting directly upstream of the multi-cycle RISC-V datapath. It accepts a byte stream on a valid/ready interface, packs bytes little-endian into 32-bit instruction words, and writes them into instruction memory from address 0 upward. It then asserts `core_run`, which releases the datapath's IF/ID/EX/MEM/WB state machine. The datapath stays held in IF while `core_run` is low.

## Interface
Parameters:
- `DEPTH`, 64: instruction memory depth in words; legal range 1..255.
- `ADDR_W`, 6: word address width; must satisfy 2^ADDR_W ≥ DEPTH.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `load_start`  in  1  one-cycle pulse that begins a load.
- `in_valid`  in  1  byte available on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction memory write strobe (one-cycle pulse).
- `imem_addr`  out  ADDR_W  word address for the write.
- `imem_wdata`  out  32  instruction word for the write.
- `core_run`  out  1  datapath released; level signal.
- `word_count`  out  8  number of words written in the current or last load.
- `busy`  out  1  high in LEN, DATA and WRITE.
- `err`  out  1  sticky load error; cleared by `load_start` or reset.

## Operation
- States: IDLE, LEN, DATA, WRITE, RUN, ERROR.
- **IDLE:** `in_ready`=0. `load_start` → LEN.
- **LEN:**
  - `in_ready`=1.
  - Accepted byte N (`in_valid && in_ready`) is the word count.
  - N=0 or N>DEPTH → ERROR with `err`=1.
  - Otherwise latch N, clear the byte index and `word_count`, then → DATA.
- **DATA:**
  - `in_ready`=1.
  - Each accepted byte goes into bits [8k+7:8k] of the word buffer, where k = byte index 0..3 (little-endian).
  - The 4th accepted byte → WRITE.
- **WRITE:**
  - `in_ready`=0.
  - `imem_we`=1, `imem_addr`=`word_count`[ADDR_W-1:0], `imem_wdata`=buffer.
  - `word_count` increments at the end of the cycle.
  - If the new count equals N → RUN (or CHECK, see Configuration); else → DATA.
- **RUN:**
  - `core_run`=1, `in_ready`=0.
  - `load_start` drops `core_run` on the next cycle, clears `err`, and → LEN (reload).
- **ERROR:** `core_run`=0, `in_ready`=0, `err`=1. `load_start` → LEN with `err` cleared.
- `load_start` is ignored in LEN, DATA and WRITE.
- Bytes presented while `in_ready`=0 are not consumed; the source must hold them.
- Arithmetic: byte index is 2 bits and wraps 3→0 on entering WRITE. `word_count` is 8 bits and never exceeds DEPTH.

## Timing
- Reset values: state IDLE; `in_ready`, `imem_we`, `core_run`, `busy`, `err` = 0; `word_count`=0; `imem_addr`=0; `imem_wdata`=0.
- Reset mid-load returns to IDLE next edge. Words already written to memory are not cleared. `core_run` stays 0.
- Byte acceptance is single-cycle. Gaps in `in_valid` stall with no state change.
- A word is exactly 4 accepted bytes plus 1 WRITE cycle. Minimum load time is 1 + 5N cycles from the first LEN acceptance to the last WRITE.
- `core_run` rises the cycle after the final WRITE (no checksum).
- `imem_we` is never high for two consecutive cycles.

## Configuration
- Macro: `PROGRAM_LOADER_CHECKSUM_EN`.
- **Defined:**
  - A running XOR of all DATA bytes is kept.
  - After the final WRITE the FSM enters CHECK with `in_ready`=1 and accepts one more byte.
  - Byte equals the XOR → RUN. Mismatch → ERROR.
  - `core_run` is delayed by one accepted byte.
- **Undefined:** no CHECK state and no XOR register; the final WRITE → RUN directly.

## Structure
- Shared package `loader_pkg`: state enum (IDLE=0, LEN=1, DATA=2, WRITE=3, RUN=4, ERROR=5, CHECK=6) and a `MAX_DEPTH`=255 constant.
- Sub-module `byte_packer`: 2-bit index plus 32-bit buffer. Inputs are a byte strobe and data. Outputs are the packed word and a `word_full` flag. It is reused by the data-memory preload.

## Test plan
- Length 2, bytes 13 05 00 00 93 05 15 00 → two `imem_we` pulses: addr0=0x00000513, addr1=0x00150593. `word_count`=2, then `core_run`=1.
- Length byte 0, and separately length DEPTH+1 → ERROR, `err`=1, no `imem_we`, `core_run`=0. Next `load_start` clears `err`.
- Length 1 with `in_valid` toggling every other cycle → same word written, `in_ready` low only in WRITE, no byte lost or duplicated.
- `rst_n` low after 6 data bytes of a 2-word load → all outputs at reset values next cycle. Only addr0 was written.
- With the macro defined, length 1 with bytes 01 02 03 04:
  - Checksum 0x04 → RUN.
  - Checksum 0x05 → ERROR with `err`=1.
- `load_start` while in RUN → `core_run` drops next cycle, then reload to the new image succeeds.
